// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with load-use bubble insertion and
// EX/MEM + MEM/WB operand forwarding feeding the ALU operand outputs.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   id_*                  decoded instruction fields and control from ID
//   stall_in, flush       downstream hold / squash of the ID/EX register
//   exmem_*, memwb_*      forwarding sources from later stages
//   op1, op2              ALU operands (forwarded, immediate-selected)
//   ex_*                  registered fields/controls, zero when not valid
//   id_stall              hold request for IF/ID and PC
module id_ex_stage (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        id_valid,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic [4:0]  id_rd,
    input  logic [31:0] id_rs_data,
    input  logic [31:0] id_rt_data,
    input  logic [31:0] id_imm,
    input  logic [4:0]  id_shamt,
    input  logic [3:0]  id_alusignal,
    input  logic        id_alusrc,
    input  logic        id_regwrite,
    input  logic        id_memread,
    input  logic        id_memwrite,
    input  logic        id_memtoreg,
    input  logic        stall_in,
    input  logic        flush,
    input  logic        exmem_regwrite,
    input  logic [4:0]  exmem_rd,
    input  logic [31:0] exmem_result,
    input  logic        memwb_regwrite,
    input  logic [4:0]  memwb_rd,
    input  logic [31:0] memwb_data,
    output logic [31:0] op1,
    output logic [31:0] op2,
    output logic [4:0]  ex_shamt,
    output logic [3:0]  ex_alusignal,
    output logic [4:0]  ex_rd,
    output logic [31:0] ex_store_data,
    output logic        ex_valid,
    output logic        ex_regwrite,
    output logic        ex_memread,
    output logic        ex_memwrite,
    output logic        ex_memtoreg,
    output logic        id_stall
);

    localparam int unsigned REG_W  = 5;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned OP_W   = 4;

    logic              valid_q, valid_d;
    logic [REG_W-1:0]  rs_q, rs_d, rt_q, rt_d, rd_q, rd_d, shamt_q, shamt_d;
    logic [DATA_W-1:0] rs_data_q, rs_data_d, rt_data_q, rt_data_d, imm_q, imm_d;
    logic [OP_W-1:0]   alusignal_q, alusignal_d;
    logic              alusrc_q, alusrc_d;
    logic              regwrite_q, regwrite_d, memread_q, memread_d;
    logic              memwrite_q, memwrite_d, memtoreg_q, memtoreg_d;

    logic              load_use_c;
    logic [DATA_W-1:0] fwd_a_c, fwd_b_c;

    // Dependent instruction in ID reads the register a load in EX is producing.
    assign load_use_c = id_valid & valid_q & memread_q & (rd_q != REG_W'(0)) &
                        ((rd_q == id_rs) | (rd_q == id_rt));

    assign id_stall = ~flush & (stall_in | load_use_c);

    // Next-state: flush > stall_in > load-use bubble > capture (bubble if !id_valid).
    always_comb begin
        valid_d     = valid_q;
        rs_d        = rs_q;
        rt_d        = rt_q;
        rd_d        = rd_q;
        rs_data_d   = rs_data_q;
        rt_data_d   = rt_data_q;
        imm_d       = imm_q;
        shamt_d     = shamt_q;
        alusignal_d = alusignal_q;
        alusrc_d    = alusrc_q;
        regwrite_d  = regwrite_q;
        memread_d   = memread_q;
        memwrite_d  = memwrite_q;
        memtoreg_d  = memtoreg_q;
        if (flush || (!stall_in && (load_use_c || !id_valid))) begin
            valid_d     = 1'b0;
            rs_d        = '0;
            rt_d        = '0;
            rd_d        = '0;
            rs_data_d   = '0;
            rt_data_d   = '0;
            imm_d       = '0;
            shamt_d     = '0;
            alusignal_d = '0;
            alusrc_d    = 1'b0;
            regwrite_d  = 1'b0;
            memread_d   = 1'b0;
            memwrite_d  = 1'b0;
            memtoreg_d  = 1'b0;
        end else if (!stall_in) begin
            valid_d     = 1'b1;
            rs_d        = id_rs;
            rt_d        = id_rt;
            rd_d        = id_rd;
            rs_data_d   = id_rs_data;
            rt_data_d   = id_rt_data;
            imm_d       = id_imm;
            shamt_d     = id_shamt;
            alusignal_d = id_alusignal;
            alusrc_d    = id_alusrc;
            regwrite_d  = id_regwrite;
            memread_d   = id_memread;
            memwrite_d  = id_memwrite;
            memtoreg_d  = id_memtoreg;
        end
    end

    // Pipeline register; reset loads a bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q     <= 1'b0;
            rs_q        <= '0;
            rt_q        <= '0;
            rd_q        <= '0;
            rs_data_q   <= '0;
            rt_data_q   <= '0;
            imm_q       <= '0;
            shamt_q     <= '0;
            alusignal_q <= '0;
            alusrc_q    <= 1'b0;
            regwrite_q  <= 1'b0;
            memread_q   <= 1'b0;
            memwrite_q  <= 1'b0;
            memtoreg_q  <= 1'b0;
        end else begin
            valid_q     <= valid_d;
            rs_q        <= rs_d;
            rt_q        <= rt_d;
            rd_q        <= rd_d;
            rs_data_q   <= rs_data_d;
            rt_data_q   <= rt_data_d;
            imm_q       <= imm_d;
            shamt_q     <= shamt_d;
            alusignal_q <= alusignal_d;
            alusrc_q    <= alusrc_d;
            regwrite_q  <= regwrite_d;
            memread_q   <= memread_d;
            memwrite_q  <= memwrite_d;
            memtoreg_q  <= memtoreg_d;
        end
    end

    // Operand forwarding: EX/MEM beats MEM/WB, r0 is never forwarded.
    always_comb begin
        fwd_a_c = rs_data_q;
        if (exmem_regwrite && (exmem_rd != REG_W'(0)) && (exmem_rd == rs_q)) begin
            fwd_a_c = exmem_result;
        end else if (memwb_regwrite && (memwb_rd != REG_W'(0)) && (memwb_rd == rs_q)) begin
            fwd_a_c = memwb_data;
        end
        fwd_b_c = rt_data_q;
        if (exmem_regwrite && (exmem_rd != REG_W'(0)) && (exmem_rd == rt_q)) begin
            fwd_b_c = exmem_result;
        end else if (memwb_regwrite && (memwb_rd != REG_W'(0)) && (memwb_rd == rt_q)) begin
            fwd_b_c = memwb_data;
        end
    end

    // EX-side outputs, all forced to zero for a bubble.
    assign op1           = valid_q ? fwd_a_c : '0;
    assign op2           = valid_q ? (alusrc_q ? imm_q : fwd_b_c) : '0;
    assign ex_store_data = valid_q ? fwd_b_c : '0;
    assign ex_shamt      = valid_q ? shamt_q : '0;
    assign ex_alusignal  = valid_q ? alusignal_q : '0;
    assign ex_rd         = valid_q ? rd_q : '0;
    assign ex_valid      = valid_q;
    assign ex_regwrite   = valid_q & regwrite_q;
    assign ex_memread    = valid_q & memread_q;
    assign ex_memwrite   = valid_q & memwrite_q;
    assign ex_memtoreg   = valid_q & memtoreg_q;

endmodule
